// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: reset vector, fetch response ID and the fetch-queue entry.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [3:0]  INST_ID_DEFAULT = 4'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic        adel;
    logic        dsi;
    logic [31:0] data;
    logic        dvalid;
  } if_entry_t;

endpackage

// File: rtl/fq_ring.sv
// In-order ring of fetch entries with head/fill/tail pointers; the pointer MSB is the wrap bit.
module fq_ring
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            alloc_i,
  input  if_entry_t       alloc_entry_i,
  input  logic            fill_i,
  input  logic [31:0]     fill_data_i,
  input  logic            pop_i,
  input  logic            clear_i,
  output if_entry_t       head_entry_o,
  output logic [PtrW-1:0] count_o,
  output logic [PtrW-1:0] pending_o
);

  localparam int unsigned IdxW = PtrW - 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  if_entry_t       mem_q [DEPTH];
  if_entry_t       mem_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] fill_base;
  logic [PtrW-1:0] fill_dist;

  function automatic logic [IdxW-1:0] slot(input logic [PtrW-1:0] ptr);
    return IdxW'(ptr);
  endfunction

  assign count_o      = tail_q - head_q;
  assign head_entry_o = mem_q[slot(head_q)];

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PtrW'(i) < count_o && !mem_q[slot(head_q + PtrW'(i))].dvalid) begin
        pending_o = pending_o + PtrOne;
      end
    end
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    // A flush discards everything queued, including a fill landing in the same cycle.
    if (clear_i) begin
      head_d = tail_q;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].dvalid = 1'b0;
      end
    end else begin
      if (fill_i) begin
        mem_d[slot(fill_q)].data   = fill_data_i;
        mem_d[slot(fill_q)].dvalid = 1'b1;
      end
      if (pop_i) begin
        head_d = head_q + PtrOne;
      end
    end
    if (alloc_i) begin
      mem_d[slot(tail_q)] = alloc_entry_i;
      tail_d              = tail_q + PtrOne;
    end

    // Fill pointer moves to the oldest entry still awaiting data; AdEL entries are born valid.
    if (clear_i) begin
      fill_base = tail_q;
    end else if (fill_i) begin
      fill_base = fill_q + PtrOne;
    end else begin
      fill_base = fill_q;
    end
    fill_dist = tail_d - fill_base;
    fill_d    = tail_d;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (PtrW'(i) < fill_dist && !mem_d[slot(fill_base + PtrW'(i))].dvalid) begin
        fill_d = fill_base + PtrW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-return queue between fetch issue and decode, with flush-time drop accounting
// so that reads already on the bus when a flush hits are drained and discarded.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH   = 4,
  parameter int unsigned     ID_W    = 4,
  parameter logic [ID_W-1:0] INST_ID = ID_W'(INST_ID_DEFAULT),
  localparam int unsigned    OccW    = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            req_valid_i,
  input  logic [31:0]     req_pc_i,
  input  logic            req_adel_i,
  input  logic            req_dsi_i,
  output logic            req_ready_o,
  input  logic            axi_rvalid_i,
  input  logic [ID_W-1:0] axi_rid_i,
  input  logic [31:0]     axi_rdata_i,
  output logic            axi_rready_o,
  input  logic            de_allowin_i,
  input  logic            flush_i,
  output logic            fe_to_de_valid_o,
  output logic [31:0]     ir_out_o,
  output logic [31:0]     pc_out_o,
  output logic [31:0]     pc_add4_out_o,
  output logic            adel_out_o,
  output logic            dsi_out_o,
  output logic [OccW-1:0] occupancy_o
);

  localparam int unsigned SumW = OccW + 1;
  localparam logic [OccW-1:0] OccOne = OccW'(1);

  logic [OccW-1:0] count;
  logic [OccW-1:0] pending;
  logic [OccW-1:0] drop_q, drop_d;
  if_entry_t       head_entry;
  if_entry_t       alloc_entry;
  logic            beat;
  logic            drop_beat;
  logic            fill_beat;
  logic            pop;
  logic            head_live;

  // Every not-yet-valid entry is a bus read: AdEL entries are marked valid at allocation.
  assign axi_rready_o = (pending != '0) || (drop_q != '0);
  assign beat         = axi_rvalid_i && axi_rready_o && (axi_rid_i == INST_ID);
  assign drop_beat    = beat && (drop_q != '0);
  assign fill_beat    = beat && (drop_q == '0);

  assign req_ready_o = (SumW'(count) + SumW'(drop_q)) < SumW'(DEPTH);

  assign fe_to_de_valid_o = head_entry.dvalid && (count != '0) && !flush_i;
  assign pop              = fe_to_de_valid_o && de_allowin_i;

  always_comb begin
    alloc_entry        = '0;
    alloc_entry.pc     = req_pc_i;
    alloc_entry.adel   = req_adel_i;
    alloc_entry.dsi    = req_dsi_i;
    alloc_entry.dvalid = req_adel_i;
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_beat) begin
      drop_d = drop_d - OccOne;
    end
    // Reads still owed by the bus become drops; a beat filling this cycle settles one of them.
    if (flush_i) begin
      drop_d = drop_d + pending;
      if (fill_beat) begin
        drop_d = drop_d - OccOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  fq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .alloc_i       (req_valid_i),
    .alloc_entry_i (alloc_entry),
    .fill_i        (fill_beat),
    .fill_data_i   (axi_rdata_i),
    .pop_i         (pop),
    .clear_i       (flush_i),
    .head_entry_o  (head_entry),
    .count_o       (count),
    .pending_o     (pending)
  );

  // Head fields read as zero while the queue is empty, which also covers reset.
  assign head_live     = (count != '0);
  assign ir_out_o      = head_live ? head_entry.data : '0;
  assign pc_out_o      = head_live ? head_entry.pc : '0;
  assign pc_add4_out_o = head_live ? (head_entry.pc + 32'd4) : '0;
  assign adel_out_o    = head_live && head_entry.adel;
  assign dsi_out_o     = head_live && head_entry.dsi;
  assign occupancy_o   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue with a queue-level reference model and scoreboard.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int              DEPTH   = 4;
  localparam int              ID_W    = 4;
  localparam logic [ID_W-1:0] INST_ID = '0;
  localparam int              OccW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            resetn;
  logic            req_valid;
  logic [31:0]     req_pc;
  logic            req_adel;
  logic            req_dsi;
  logic            req_ready;
  logic            axi_rvalid;
  logic [ID_W-1:0] axi_rid;
  logic [31:0]     axi_rdata;
  logic            axi_rready;
  logic            de_allowin;
  logic            flush;
  logic            fe_to_de_valid;
  logic [31:0]     ir_out;
  logic [31:0]     pc_out;
  logic [31:0]     pc_add4_out;
  logic            adel_out;
  logic            dsi_out;
  logic [OccW-1:0] occupancy;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ID_W    (ID_W),
    .INST_ID (INST_ID)
  ) dut (
    .clk_i            (clk),
    .resetn_i         (resetn),
    .req_valid_i      (req_valid),
    .req_pc_i         (req_pc),
    .req_adel_i       (req_adel),
    .req_dsi_i        (req_dsi),
    .req_ready_o      (req_ready),
    .axi_rvalid_i     (axi_rvalid),
    .axi_rid_i        (axi_rid),
    .axi_rdata_i      (axi_rdata),
    .axi_rready_o     (axi_rready),
    .de_allowin_i     (de_allowin),
    .flush_i          (flush),
    .fe_to_de_valid_o (fe_to_de_valid),
    .ir_out_o         (ir_out),
    .pc_out_o         (pc_out),
    .pc_add4_out_o    (pc_add4_out),
    .adel_out_o       (adel_out),
    .dsi_out_o        (dsi_out),
    .occupancy_o      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        adel;
    logic        dsi;
    logic [31:0] data;
    logic        has;
    logic [31:0] avail;
  } rec_t;

  rec_t mdl[$];    // fetches in issue order, front still waiting for data
  rec_t exp_q[$];  // fully known fetches, next ones decode must see
  int   drop;
  int   cyc;
  int   checks;
  int   passes;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic int pending_bus();
    int n = 0;
    foreach (mdl[i]) if (!mdl[i].has) n++;
    return n;
  endfunction

  function automatic int live();
    return mdl.size() + exp_q.size();
  endfunction

  task automatic drive(input logic rq, input logic [31:0] pc, input logic adel, input logic dsi,
                       input logic rv, input logic [ID_W-1:0] rid, input logic [31:0] rd,
                       input logic alw, input logic fl);
    int   pend;
    logic acc;
    rec_t r;
    @(posedge clk);
    #1;
    pend = pending_bus();
    chk("occupancy", 32'(occupancy), 32'(live()));
    chk("req_ready", 32'(req_ready), 32'((live() + drop) < DEPTH));
    chk("axi_rready", 32'(axi_rready), 32'((pend > 0) || (drop > 0)));
    if ((live() + drop) >= DEPTH) rq = 1'b0;
    req_valid  = rq;
    req_pc     = pc;
    req_adel   = adel;
    req_dsi    = dsi;
    axi_rvalid = rv;
    axi_rid    = rid;
    axi_rdata  = rd;
    de_allowin = alw;
    flush      = fl;
    acc = rv && (rid == INST_ID) && ((pend > 0) || (drop > 0));
    if (fl) begin
      if (acc && drop > 0) drop--;
      else if (acc) pend--;
      drop += pend;
      mdl.delete();
      exp_q.delete();
    end else if (acc) begin
      if (drop > 0) drop--;
      else begin
        for (int i = 0; i < mdl.size(); i++) begin
          if (!mdl[i].has) begin
            r       = mdl[i];
            r.data  = rd;
            r.has   = 1'b1;
            r.avail = 32'(cyc + 1);
            mdl[i]  = r;
            break;
          end
        end
      end
    end
    if (rq) begin
      r = '{pc: pc, adel: adel, dsi: dsi, data: 32'd0, has: adel, avail: 32'(cyc + 1)};
      mdl.push_back(r);
    end
    while (mdl.size() > 0 && mdl[0].has) exp_q.push_back(mdl.pop_front());
  endtask

  task automatic idle(input int n, input logic alw);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, '0, 32'd0, alw, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic adel, input logic alw);
    drive(1'b1, pc, adel, 1'b0, 1'b0, '0, 32'd0, alw, 1'b0);
  endtask

  task automatic beat(input logic [ID_W-1:0] rid, input logic [31:0] rd, input logic alw);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, rid, rd, alw, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " fe_to_de_valid"}, 32'(fe_to_de_valid), 32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " axi_rready"}, 32'(axi_rready), 32'd0);
    chk({tag, " occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, " ir_out"}, ir_out, 32'd0);
    chk({tag, " pc_out"}, pc_out, 32'd0);
    chk({tag, " pc_add4_out"}, pc_add4_out, 32'd0);
    chk({tag, " adel_dsi"}, 32'({adel_out, dsi_out}), 32'd0);
  endtask

  // Monitor: compares the head against the scoreboard whenever decode could take it.
  always @(negedge clk) begin
    logic ev;
    rec_t e;
    if (resetn) begin
      ev = 1'b0;
      if (exp_q.size() > 0) begin
        e  = exp_q[0];
        ev = (e.avail <= 32'(cyc)) && !flush;
      end
      chk("fe_to_de_valid", 32'(fe_to_de_valid), 32'(ev));
      if (ev && fe_to_de_valid) begin
        chk("ir_out", ir_out, e.data);
        chk("pc_out", pc_out, e.pc);
        chk("pc_add4_out", pc_add4_out, e.pc + 32'd4);
        chk("adel_out", 32'(adel_out), 32'(e.adel));
        chk("dsi_out", 32'(dsi_out), 32'(e.dsi));
        if (de_allowin) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic        adel;
    int          guard;
    checks = 0; passes = 0; drop = 0; cyc = 0;
    resetn = 1'b0; req_valid = 1'b0; req_pc = '0; req_adel = 1'b0; req_dsi = 1'b0;
    axi_rvalid = 1'b0; axi_rid = '0; axi_rdata = '0; de_allowin = 1'b0; flush = 1'b0;
    #12;
    check_reset_outputs("por");
    resetn = 1'b1;

    // Reset mid-traffic with three reads outstanding.
    fetch(RESET_PC, 1'b0, 1'b1);
    fetch(RESET_PC + 32'd4, 1'b0, 1'b1);
    fetch(RESET_PC + 32'd8, 1'b0, 1'b1);
    #2;
    resetn = 1'b0; req_valid = 1'b0; axi_rvalid = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    mdl.delete(); exp_q.delete(); drop = 0;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    beat('0, 32'hdead0001, 1'b1);
    beat('0, 32'hdead0002, 1'b1);
    idle(2, 1'b1);

    // Pipelined fill, in order, first valid one cycle after the first beat.
    fetch(RESET_PC, 1'b0, 1'b1);
    drive(1'b1, RESET_PC + 32'd4, 1'b0, 1'b0, 1'b1, '0, 32'h11, 1'b1, 1'b0);
    drive(1'b1, RESET_PC + 32'd8, 1'b0, 1'b1, 1'b1, '0, 32'h22, 1'b1, 1'b0);
    drive(1'b1, RESET_PC + 32'hc, 1'b0, 1'b0, 1'b1, '0, 32'h33, 1'b1, 1'b0);
    beat('0, 32'h44, 1'b1);
    idle(3, 1'b1);

    // Full queue and backpressure.
    for (int i = 0; i < DEPTH; i++) fetch(32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) beat('0, 32'h100 + 32'(i), 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Foreign RID between instruction beats.
    fetch(RESET_PC + 32'h20, 1'b0, 1'b1);
    fetch(RESET_PC + 32'h24, 1'b0, 1'b1);
    beat('0, 32'haaaa0001, 1'b1);
    beat(4'd1, 32'hbbbb0001, 1'b1);
    beat('0, 32'haaaa0002, 1'b1);
    idle(3, 1'b1);

    // AdEL fetch sandwiched between two normal fetches.
    fetch(RESET_PC + 32'h40, 1'b0, 1'b1);
    fetch(RESET_PC + 32'h1, 1'b1, 1'b1);
    fetch(RESET_PC + 32'h44, 1'b0, 1'b1);
    beat('0, 32'hc0de0001, 1'b1);
    beat('0, 32'hc0de0002, 1'b1);
    beat('0, 32'hc0de0003, 1'b1);
    idle(3, 1'b1);

    // Flush with three reads in flight plus a redirect fetch.
    fetch(RESET_PC + 32'h60, 1'b0, 1'b1);
    fetch(RESET_PC + 32'h64, 1'b0, 1'b1);
    fetch(RESET_PC + 32'h68, 1'b0, 1'b1);
    drive(1'b1, 32'hbfc00380, 1'b0, 1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) beat('0, 32'hf100 + 32'(i), 1'b1);
    idle(3, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      adel = ($urandom_range(0, 9) == 0);
      pc   = $urandom();
      pc   = adel ? (pc | 32'h1) : (pc & ~32'h3);
      drive($urandom_range(0, 99) < 45, pc, adel, $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) < 55,
            ($urandom_range(0, 3) == 0) ? ID_W'($urandom_range(1, 15)) : INST_ID,
            $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    // Drain with a bounded budget.
    guard = 0;
    while ((live() > 0 || drop > 0) && guard < 300) begin
      beat(INST_ID, $urandom(), 1'b1);
      guard++;
    end
    idle(3, 1'b1);
    chk("drained", 32'(live() + drop), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
